// File: rtl/lc3_program_loader.sv
// lc3_program_loader
// Parses an object-image byte frame (origin, count, data words, XOR checksum)
// from a valid/ready byte stream, writes each word through the LC-3 memory
// special load port, and keeps the processor in reset until a complete,
// checksum-valid image has arrived.
module lc3_program_loader #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rearm,
    output logic [15:0] MARSpcIn,
    output logic [15:0] MDRSpcIn,
    output logic        ldMARSpcIn,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [3:0] {
        S_ORG_HI,
        S_ORG_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic [15:0] r_addr;
    logic [15:0] r_remaining;
    logic [7:0]  r_csum;
    logic [7:0]  r_dat_hi;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic        r_ld;
    logic        r_cpu_hold;
    logic        r_load_done;
    logic        r_load_error;
    logic        w_xfer;

    // r_in_ready always tracks the state it was loaded alongside, so a
    // transfer is purely a function of the registered ready and in_valid.
    assign w_xfer     = in_valid & r_in_ready;

    // Ready is forced low while reset is held so no byte appears accepted.
    assign in_ready   = r_in_ready & ~reset;
    assign MARSpcIn   = r_mar;
    assign MDRSpcIn   = r_mdr;
    assign ldMARSpcIn = r_ld;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

    // Frame parser FSM with its address/count/checksum registers and all
    // registered outputs; ready is updated together with every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_ORG_HI;
            r_in_ready   <= 1'b1;
            r_addr       <= 16'h0000;
            r_remaining  <= 16'h0000;
            r_csum       <= 8'h00;
            r_dat_hi     <= 8'h00;
            r_mar        <= 16'h0000;
            r_mdr        <= 16'h0000;
            r_ld         <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_ld <= 1'b0;
            if (w_xfer && (r_state != S_CHK)) begin
                r_csum <= r_csum ^ in_data;
            end
            case (r_state)
                S_ORG_HI: begin
                    if (w_xfer) begin
                        r_addr[15:8] <= in_data;
                        r_state      <= S_ORG_LO;
                    end
                end
                S_ORG_LO: begin
                    if (w_xfer) begin
                        r_addr[7:0] <= in_data;
                        r_state     <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        r_remaining[15:8] <= in_data;
                        r_state           <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_xfer) begin
                        r_remaining[7:0] <= in_data;
                        if ({r_remaining[15:8], in_data} != 16'h0000) begin
                            r_state <= S_DAT_HI;
                        end else begin
                            r_state <= S_CHK;
                        end
                    end
                end
                S_DAT_HI: begin
                    if (w_xfer) begin
                        r_dat_hi <= in_data;
                        r_state  <= S_DAT_LO;
                    end
                end
                S_DAT_LO: begin
                    // Present the write for the whole S_WRITE cycle.
                    if (w_xfer) begin
                        r_mar      <= r_addr;
                        r_mdr      <= {r_dat_hi, in_data};
                        r_ld       <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_addr      <= r_addr + 16'd1;
                    r_remaining <= r_remaining - 16'd1;
                    r_in_ready  <= 1'b1;
                    if (r_remaining != 16'd1) begin
                        r_state <= S_DAT_HI;
                    end else begin
                        r_state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_load_done <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_DONE;
                        if (CHECK_EN && (in_data != r_csum)) begin
                            r_load_error <= 1'b1;
                        end else begin
                            r_cpu_hold <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    // MAR/MDR deliberately keep their last values across rearm.
                    if (rearm) begin
                        r_cpu_hold   <= 1'b1;
                        r_load_error <= 1'b0;
                        r_load_done  <= 1'b0;
                        r_csum       <= 8'h00;
                        r_in_ready   <= 1'b1;
                        r_state      <= S_ORG_HI;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_ORG_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_program_loader.sv
// Testbench for lc3_program_loader: randomized byte frames against a
// frame-level reference model (expected write list and error outcome).
module tb_lc3_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        rearm = 1'b0;

    logic        rdy0, ld0, hold0, done0, err0;
    logic [15:0] mar0, mdr0;
    logic        rdy1, ld1, hold1, done1, err1;
    logic [15:0] mar1, mdr1;

    lc3_program_loader #(.CHECK_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .rearm(rearm), .MARSpcIn(mar0), .MDRSpcIn(mdr0),
        .ldMARSpcIn(ld0), .cpu_hold(hold0), .load_done(done0), .load_error(err0)
    );

    lc3_program_loader #(.CHECK_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .rearm(rearm), .MARSpcIn(mar1), .MDRSpcIn(mdr1),
        .ldMARSpcIn(ld1), .cpu_hold(hold1), .load_done(done1), .load_error(err1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wq[$];
    logic [7:0]  frame[$];
    logic [31:0] exp_w[$];
    logic [31:0] obs_w[$];
    bit          mon_en = 1'b0;
    int          viol_ready = 0;
    int          viol_hold = 0;
    int          lat_err = 0;

    // Record write pulses and watch handshake/hold invariants every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ld0 === 1'b1) obs_w.push_back({mar0, mdr0});
            if (ld0 === 1'b1 && rdy0 !== 1'b0) viol_ready++;
            if (!reset && ld0 === 1'b0 && done0 === 1'b0 && rdy0 !== 1'b1) viol_ready++;
            if (done0 === 1'b0 && hold0 !== 1'b1) viol_hold++;
        end
    end

    // Reference model: frame bytes and expected writes from origin + words.
    task automatic build_frame(input logic [15:0] org, input logic [7:0] bad_xor);
        logic [7:0]  chk;
        logic [15:0] cnt;
        frame.delete();
        exp_w.delete();
        cnt = 16'(wq.size());
        frame.push_back(org[15:8]);
        frame.push_back(org[7:0]);
        frame.push_back(cnt[15:8]);
        frame.push_back(cnt[7:0]);
        for (int i = 0; i < wq.size(); i++) begin
            frame.push_back(wq[i][15:8]);
            frame.push_back(wq[i][7:0]);
            exp_w.push_back({org + 16'(i), wq[i]});
        end
        chk = 8'h00;
        foreach (frame[i]) chk = chk ^ frame[i];
        frame.push_back(chk ^ bad_xor);
    endtask

    // Drive the first nb bytes of frame with random in_valid gaps (percent).
    task automatic send_frame(input int gap, input int nb);
        bit pend_lat = 1'b0;
        bit xfer;
        int waitc;
        for (int i = 0; i < nb; i++) begin
            waitc = 0;
            while (1) begin
                @(negedge clk);
                if (pend_lat) begin
                    if (ld0 !== 1'b1) lat_err++;
                    pend_lat = 1'b0;
                end
                in_data  = frame[i];
                in_valid = ($urandom_range(99) >= gap);
                xfer     = in_valid && (rdy0 === 1'b1);
                @(posedge clk);
                if (xfer) begin
                    if (i >= 4 && i < frame.size() - 1 && ((i - 4) % 2) == 1) pend_lat = 1'b1;
                    break;
                end
                waitc++;
                if (waitc > 300) begin
                    n_tests++; n_fail++;
                    $display("FAIL byte_timeout idx %0d: in_ready stayed %b, required 1", i, rdy0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        if (pend_lat && ld0 !== 1'b1) lat_err++;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; rearm = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        obs_w.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; rearm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({rdy0, ld0, hold0, done0, err0} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy/ld/hold/done/err=%b required 00100", {rdy0, ld0, hold0, done0, err0});
        end
        n_tests++;
        if ({mar0, mdr0} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mar_mdr got %h required 00000000", {mar0, mdr0});
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after got %b required 1", rdy0);
        end
        mon_en = 1'b1;
        obs_w.delete();
    endtask

    task automatic test_basic();
        do_reset();
        wq = '{16'h1234, 16'hABCD};
        build_frame(16'h3000, 8'h00);
        send_frame(0, frame.size());
        n_tests++;
        if (obs_w.size() != 2) begin
            n_fail++;
            $display("FAIL basic_count got %0d writes required 2", obs_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_tests++;
            if (obs_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL basic_write[%0d] got %h required %h", i, obs_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_flags got done/err/hold=%b required 100", {done0, err0, hold0});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wq = '{16'h0001, 16'h0002};
        build_frame(16'hFFFF, 8'h00);
        send_frame(0, frame.size());
        n_tests++;
        if (obs_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL wrap_count got %0d writes required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_tests++;
            if (obs_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL wrap_write[%0d] got %h required %h", i, obs_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL wrap_flags got done/err/hold=%b required 100", {done0, err0, hold0});
        end
    endtask

    task automatic test_empty();
        do_reset();
        wq.delete();
        build_frame(16'h4000, 8'h00);
        send_frame(0, frame.size());
        n_tests++;
        if (obs_w.size() != 0) begin
            n_fail++;
            $display("FAIL empty_count got %0d writes required 0", obs_w.size());
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL empty_flags got done/err/hold=%b required 100", {done0, err0, hold0});
        end
    endtask

    task automatic test_bad_chk();
        do_reset();
        wq = '{16'h1234, 16'hABCD};
        build_frame(16'h3000, 8'h01);
        send_frame(0, frame.size());
        n_tests++;
        if (obs_w.size() != 2 || obs_w[0] !== exp_w[0] || obs_w[1] !== exp_w[1]) begin
            n_fail++;
            $display("FAIL badchk_writes got %0d writes, first %h, required 2 writes starting %h",
                     obs_w.size(), (obs_w.size() > 0) ? obs_w[0] : 32'h0, exp_w[0]);
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b111) begin
            n_fail++;
            $display("FAIL badchk_flags got done/err/hold=%b required 111", {done0, err0, hold0});
        end
        n_tests++;
        if ({done1, err1, hold1} !== 3'b100) begin
            n_fail++;
            $display("FAIL badchk_nocheck_flags got done/err/hold=%b required 100", {done1, err1, hold1});
        end
    endtask

    task automatic test_stall();
        do_reset();
        wq = '{16'h1234, 16'hABCD};
        build_frame(16'h3000, 8'h00);
        send_frame(45, frame.size());
        n_tests++;
        if (obs_w.size() != 2) begin
            n_fail++;
            $display("FAIL stall_count got %0d writes required 2", obs_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_tests++;
            if (obs_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL stall_write[%0d] got %h required %h", i, obs_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL stall_flags got done/err/hold=%b required 100", {done0, err0, hold0});
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        wq = '{16'h1234, 16'hABCD};
        build_frame(16'h3000, 8'h00);
        send_frame(0, 6);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({hold0, done0, ld0} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_ctrl got hold/done/ld=%b required 100", {hold0, done0, ld0});
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
            n_fail++;
            $display("FAIL midreset_partial got %0d writes required 1 write %h", obs_w.size(), exp_w[0]);
        end
        obs_w.delete();
        send_frame(0, frame.size());
        n_tests++;
        if (obs_w.size() != 2) begin
            n_fail++;
            $display("FAIL midreset_count got %0d writes required 2", obs_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_tests++;
            if (obs_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL midreset_write[%0d] got %h required %h", i, obs_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_flags got done/err/hold=%b required 100", {done0, err0, hold0});
        end
    endtask

    task automatic test_rearm();
        do_reset();
        wq = '{16'h1234, 16'hABCD};
        build_frame(16'h3000, 8'h01);
        send_frame(0, frame.size());
        @(negedge clk);
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        n_tests++;
        if ({err0, hold0, done0, rdy0} !== 4'b0101) begin
            n_fail++;
            $display("FAIL rearm_flags got err/hold/done/rdy=%b required 0101", {err0, hold0, done0, rdy0});
        end
        obs_w.delete();
        wq = '{16'h5A5A, 16'h0F0F, 16'hC3C3};
        build_frame(16'h1200, 8'h00);
        send_frame(25, frame.size());
        n_tests++;
        if (obs_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL rearm_count got %0d writes required %0d", obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_tests++;
            if (obs_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL rearm_write[%0d] got %h required %h", i, obs_w[i], exp_w[i]);
            end
        end
        n_tests++;
        if ({done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL rearm_done_flags got done/err/hold=%b required 100", {done0, err0, hold0});
        end
    endtask

    task automatic test_random();
        logic [7:0]  bx;
        logic [15:0] org;
        int          n;
        for (int t = 0; t < 10; t++) begin
            if (t % 2 == 0) begin
                do_reset();
            end else begin
                @(negedge clk);
                rearm = 1'b1;
                @(negedge clk);
                rearm = 1'b0;
                obs_w.delete();
            end
            org = 16'($urandom);
            n = $urandom_range(0, 6);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
            bx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build_frame(org, bx);
            send_frame($urandom_range(0, 50), frame.size());
            n_tests++;
            if (obs_w.size() != exp_w.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count got %0d writes required %0d", t, obs_w.size(), exp_w.size());
            end
            for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
                n_tests++;
                if (obs_w[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_write[%0d] got %h required %h", t, i, obs_w[i], exp_w[i]);
                end
            end
            n_tests++;
            if ({done0, err0, hold0} !== {1'b1, bx != 8'h00, bx != 8'h00}) begin
                n_fail++;
                $display("FAIL rand%0d_flags got done/err/hold=%b required %b", t,
                         {done0, err0, hold0}, {1'b1, bx != 8'h00, bx != 8'h00});
            end
            n_tests++;
            if ({done1, err1, hold1} !== 3'b100) begin
                n_fail++;
                $display("FAIL rand%0d_nocheck_flags got done/err/hold=%b required 100", t, {done1, err1, hold1});
            end
        end
    endtask

    task automatic test_invariants();
        n_tests++;
        if (viol_ready !== 0) begin
            n_fail++;
            $display("FAIL ready_pattern got %0d bad cycles required 0", viol_ready);
        end
        n_tests++;
        if (viol_hold !== 0) begin
            n_fail++;
            $display("FAIL hold_while_loading got %0d bad cycles required 0", viol_hold);
        end
        n_tests++;
        if (lat_err !== 0) begin
            n_fail++;
            $display("FAIL write_latency got %0d late strobes required 0", lat_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_bad_chk();
        test_stall();
        test_reset_midload();
        test_rearm();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
